// File: rtl/gaussian5_sep_if.sv
// ----------------------------------------------------------------------------
// gaussian5_sep_if
//
// Purpose : Groups the pixel-in / pixel-out stream signals of gaussian5_sep.
//
// Handshake: a producer asserts in_valid for one cycle per pixel. The pixel on
//   din (and in_sof) is taken on that rising edge. There is no ready signal,
//   so the consumer must take every valid beat, and gaps are allowed.
//   The output side works the same way: out_valid marks one pixel on dout for
//   exactly one cycle, and out_sof qualifies the first pixel of a frame.
//
// Signals:
//   in_valid  : input pixel qualifier
//   in_sof    : start of frame, qualified by in_valid (pixel row 0, col 0)
//   din       : input pixel, DW bits, raster order
//   out_valid : dout holds a filtered pixel this cycle
//   out_sof   : first filtered pixel of a frame
//   dout      : filtered pixel, DW bits
//
// Modports:
//   master : stream source / sink side (drives in_*, observes out_*)
//   slave  : filter side (observes in_*, drives out_*)
// ----------------------------------------------------------------------------
interface gaussian5_sep_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] din;
    logic          out_valid;
    logic          out_sof;
    logic [DW-1:0] dout;

    modport master (
        output in_valid,
        output in_sof,
        output din,
        input  out_valid,
        input  out_sof,
        input  dout
    );

    modport slave (
        input  in_valid,
        input  in_sof,
        input  din,
        output out_valid,
        output out_sof,
        output dout
    );
endinterface

// File: rtl/gaussian5_sep.sv
// ----------------------------------------------------------------------------
// gaussian5_sep
//
// Purpose : 5x5 separable Gaussian blur for the SIFT scale-space front end.
//   The raster stream goes through a registered horizontal 5-tap pass. The
//   horizontal results feed four cascaded line buffers, and a registered
//   vertical 5-tap pass follows. Only fully covered ("valid-mode") pixels are
//   emitted, giving an output frame of (IMG_W-4) x (IMG_H-4) pixels.
//
// Pipeline (fixed latency, advances every clock):
//   edge t   : pixel accepted, captured with its (row, col) position
//   edge t+1 : horizontal sum normalised into hreg
//   edge t+2 : vertical sum normalised into dout, out_valid asserted
//
// Parameters:
//   DW     : pixel width in and out
//   IMG_W  : pixels per line (>= 5)
//   IMG_H  : lines per frame (>= 5)
//   K1..K3 : outer / inner / centre tap coefficients
//   SHIFT  : normalisation shift; 2*K1 + 2*K2 + K3 must equal 2**SHIFT
//
// Ports:
//   clk    : single clock, rising edge
//   rst    : asynchronous active-low reset
//   pix_if : gaussian5_sep_if.slave stream (in_valid/in_sof/din in,
//            out_valid/out_sof/dout out)
//
// Configuration macro:
//   GAUSS_ROUND_EN : when defined, both normalisations round half up,
//                    (sum + 2**(SHIFT-1)) >> SHIFT. When undefined, both
//                    normalisations truncate, sum >> SHIFT.
// ----------------------------------------------------------------------------
module gaussian5_sep #(
    parameter int DW    = 8,
    parameter int IMG_W = 400,
    parameter int IMG_H = 300,
    parameter int K1    = 6,
    parameter int K2    = 58,
    parameter int K3    = 128,
    parameter int SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst,
    gaussian5_sep_if.slave    pix_if
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int AW   = DW + SHIFT + 1;   // accumulator width
    localparam int LB_D = IMG_W - 4;        // horizontal results per line
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_4    = CW'(4);
    localparam logic [RW-1:0] ROW_4    = RW'(4);

    localparam logic [AW-1:0] K1W = AW'(K1);
    localparam logic [AW-1:0] K2W = AW'(K2);
    localparam logic [AW-1:0] K3W = AW'(K3);

`ifdef GAUSS_ROUND_EN
    localparam logic [AW-1:0] RND = AW'(1) << (SHIFT - 1);
`else
    localparam logic [AW-1:0] RND = '0;
`endif

    // Symmetric 5-tap sum: a is the newest sample, e the oldest.
    function automatic logic [AW-1:0] taps5(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] c,
        input logic [DW-1:0] d,
        input logic [DW-1:0] e
    );
        return K1W * AW'(a) + K2W * AW'(b) + K3W * AW'(c)
             + K2W * AW'(d) + K1W * AW'(e);
    endfunction

    // Coefficients sum to 2**SHIFT, so the shifted result (with or without
    // the rounding offset) never exceeds 2**DW-1 and no saturation is needed.
    function automatic logic [DW-1:0] norm(input logic [AW-1:0] s);
        return DW'((s + RND) >> SHIFT);
    endfunction

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    // An accepted in_sof overrides the running counters for that pixel.
    // This makes mid-frame resync and the normal wrap onto (0,0) behave
    // identically.
    always_comb begin
        cur_col = pix_if.in_sof ? '0 : col_q;
        cur_row = pix_if.in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (pix_if.in_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ------------------------------------------------------------------
    // Capture stage: accepted pixel plus its position
    // ------------------------------------------------------------------
    logic          p_valid_q;
    logic [DW-1:0] p_din_q;
    logic [CW-1:0] p_col_q;
    logic [RW-1:0] p_row_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_valid_q <= 1'b0;
            p_din_q   <= '0;
            p_col_q   <= '0;
            p_row_q   <= '0;
        end else begin
            p_valid_q <= pix_if.in_valid;
            if (pix_if.in_valid) begin
                p_din_q <= pix_if.din;
                p_col_q <= cur_col;
                p_row_q <= cur_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Horizontal stage
    // ------------------------------------------------------------------
    logic [DW-1:0] s1_q, s2_q, s3_q, s4_q;   // s1 newest, s4 oldest
    logic [DW-1:0] hreg_q, hreg_d;
    logic [AW-1:0] h_sum;
    logic          hvalid_q;
    logic          h_rowok_q;   // source row of hreg is >= 4
    logic          h_sof_q;     // source position of hreg is (4,4)

    always_comb begin
        h_sum  = taps5(p_din_q, s1_q, s2_q, s3_q, s4_q);
        hreg_d = norm(h_sum);
    end

    // hvalid only for columns >= 4, where the window lies fully inside the
    // current line. Stale shift-register contents at columns 0..3 are never
    // used.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            s4_q      <= '0;
            hreg_q    <= '0;
            hvalid_q  <= 1'b0;
            h_rowok_q <= 1'b0;
            h_sof_q   <= 1'b0;
        end else begin
            hvalid_q  <= p_valid_q && (p_col_q >= COL_4);
            h_rowok_q <= (p_row_q >= ROW_4);
            h_sof_q   <= p_valid_q && (p_row_q == ROW_4) && (p_col_q == COL_4);
            if (p_valid_q) begin
                s1_q   <= p_din_q;
                s2_q   <= s1_q;
                s3_q   <= s2_q;
                s4_q   <= s3_q;
                hreg_q <= hreg_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: four cascaded FIFOs of LB_D horizontal results each.
    // Exactly LB_D hvalid beats occur per line, so the tail of buffer k
    // holds the result from the same column k+1 lines earlier.
    // ------------------------------------------------------------------
    logic [DW-1:0] lb_q [4][LB_D];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < LB_D; j++) begin
                    lb_q[k][j] <= '0;
                end
            end
        end else if (hvalid_q) begin
            for (int k = 0; k < 4; k++) begin
                lb_q[k][0] <= (k == 0) ? hreg_q : lb_q[k-1][LB_D-1];
                for (int j = 1; j < LB_D; j++) begin
                    lb_q[k][j] <= lb_q[k][j-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Vertical stage
    // ------------------------------------------------------------------
    logic [AW-1:0] v_sum;
    logic [DW-1:0] dout_q, dout_d;
    logic          out_valid_q;
    logic          out_sof_q;

    always_comb begin
        v_sum  = taps5(hreg_q, lb_q[0][LB_D-1], lb_q[1][LB_D-1],
                       lb_q[2][LB_D-1], lb_q[3][LB_D-1]);
        dout_d = norm(v_sum);
    end

    // Output gating uses the row captured with the pixel. After a resync the
    // first four rows refill the line buffers before any output is allowed,
    // so data from an aborted frame never reaches dout with out_valid set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            out_valid_q <= hvalid_q && h_rowok_q;
            out_sof_q   <= hvalid_q && h_sof_q;
            if (hvalid_q) begin
                dout_q <= dout_d;
            end
        end
    end

    assign pix_if.out_valid = out_valid_q;
    assign pix_if.out_sof   = out_sof_q;
    assign pix_if.dout      = dout_q;

endmodule

// File: tb/tb_gaussian5_sep.sv
// ----------------------------------------------------------------------------
// tb_gaussian5_sep
//
// Directed bench for gaussian5_sep at IMG_W = IMG_H = 8 (16 outputs/frame).
// Scenarios: reset values, flat field, impulse, gapped input, mid-frame
// resync, reset during row 5, back-to-back frames without a second in_sof.
// Expected pixels, out_sof flags and arrival times (accept edge + 2 cycles)
// are queued by the driver and consumed by a negedge monitor.
// ----------------------------------------------------------------------------
module tb_gaussian5_sep;

    localparam int DW  = 8;
    localparam int W   = 8;
    localparam int H   = 8;
    localparam int PER = 10;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    gaussian5_sep_if #(.DW(DW)) bus ();

    gaussian5_sep #(
        .DW    (DW),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pix_if (bus)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int            n_cmp;
    int            n_err;
    logic [DW-1:0] exp_q[$];
    logic          exp_sof_q[$];
    logic [31:0]   exp_t_q[$];
    logic [DW-1:0] imp_tab [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [DW-1:0] ed;
        logic          es;
        logic [31:0]   et;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_out: observed dout=%0d at t=%0t, expected no output",
                       bus.dout, $time);
            end else begin
                ed = exp_q.pop_front();
                es = exp_sof_q.pop_front();
                et = exp_t_q.pop_front();
                check("dout", {24'b0, bus.dout}, {24'b0, ed});
                check("out_sof", {31'b0, bus.out_sof}, {31'b0, es});
                check("out_time", 32'($time), et);
            end
        end else begin
            check("sof_without_valid", {31'b0, bus.out_sof}, 32'd0);
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic sof, input logic [DW-1:0] d,
                        input bit push, input logic [DW-1:0] ev, input logic es);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.din      = d;
        @(posedge clk);
        if (push) begin
            exp_q.push_back(ev);
            exp_sof_q.push_back(es);
            exp_t_q.push_back(32'($time) + 32'(2*PER + PER/2));
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.din      = '0;
    endtask

    // Flat frame of val, or an impulse of 255 at (4,4) on zeros.
    task automatic send_frame(input bit impulse, input logic [DW-1:0] val,
                              input bit with_sof, input int gap);
        logic [DW-1:0] d;
        logic [DW-1:0] ev;
        bit            done_win;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                d        = impulse ? ((r == 4 && c == 4) ? 8'd255 : 8'd0) : val;
                done_win = (r >= 4) && (c >= 4);
                ev       = val;
                if (impulse && done_win) ev = imp_tab[(r-4)*(W-4) + (c-4)];
                send(with_sof && r == 0 && c == 0, d, done_win, ev, (r == 4) && (c == 4));
                if (gap > 0) idle(gap);
            end
        end
    endtask

    task automatic drain_check(input string tag);
        idle(6);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        n_cmp        = 0;
        n_err        = 0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.din      = '0;
        rst          = 1'b0;
`ifdef GAUSS_ROUND_EN
        imp_tab = '{8'd0, 8'd1, 8'd3,  8'd1,
                    8'd1, 8'd13, 8'd29, 8'd13,
                    8'd3, 8'd29, 8'd64, 8'd29,
                    8'd1, 8'd13, 8'd29, 8'd13};
`else
        imp_tab = '{8'd0, 8'd1, 8'd2,  8'd1,
                    8'd1, 8'd12, 8'd28, 8'd12,
                    8'd2, 8'd28, 8'd63, 8'd28,
                    8'd1, 8'd12, 8'd28, 8'd12};
`endif

        // Reset values
        idle(2);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_out_sof",   {31'b0, bus.out_sof},   32'd0);
        check("reset_dout",      {24'b0, bus.dout},      32'd0);
        rst = 1'b1;
        idle(2);

        // Flat field, contiguous
        send_frame(1'b0, 8'd100, 1'b1, 0);
        drain_check("flat_drain");

        // Impulse at (4,4)
        send_frame(1'b1, 8'd0, 1'b1, 0);
        drain_check("impulse_drain");

        // Flat field, valid every third cycle
        send_frame(1'b0, 8'd100, 1'b1, 2);
        drain_check("gapped_drain");

        // Mid-frame resync: 20 pixels of junk, then a new frame with in_sof
        for (int i = 0; i < 20; i++) begin
            send(i == 0, 8'($urandom_range(200, 255)), 1'b0, 8'd0, 1'b0);
        end
        send_frame(1'b0, 8'd50, 1'b1, 0);
        drain_check("resync_drain");

        // Reset during row 5 while an output pixel is on the bus
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < W; c++) begin
                send(r == 0 && c == 0, 8'd100, (r >= 4) && (c >= 4), 8'd100,
                     (r == 4) && (c == 4));
            end
        end
        for (int c = 0; c < 5; c++) begin
            send(1'b0, 8'd100, c == 4, 8'd100, 1'b0);
        end
        idle(2);
        #5;
        check("pre_reset_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("pre_reset_dout",      {24'b0, bus.dout},      32'd100);
        rst = 1'b0;
        #1;
        check("async_reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async_reset_out_sof",   {31'b0, bus.out_sof},   32'd0);
        check("async_reset_dout",      {24'b0, bus.dout},      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        send_frame(1'b0, 8'd100, 1'b0, 0);
        drain_check("post_reset_drain");

        // Back-to-back frames, second one without in_sof
        send_frame(1'b0, 8'd100, 1'b1, 0);
        send_frame(1'b0, 8'd50,  1'b0, 0);
        drain_check("b2b_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
